// File: rtl/noc_pkg.sv
// Shared NoC definitions: configure-word layout, field widths and the
// injector FSM state encoding.
package noc_pkg;

    localparam int unsigned DATA_W = 9;
    localparam int unsigned DEST_W = 2;
    localparam int unsigned CFG_W  = DEST_W + DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } tx_state_e;

    // Word presented on pN_configure; all-zero means idle.
    typedef struct packed {
        logic [DEST_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } cfg_word_t;

endpackage

// File: rtl/noc_proc_injector_if.sv
// Local processor -> injector message handshake.
//   msg_valid : processor offers a message
//   msg_ready : injector accepts it this cycle
//   msg_dest  : destination router id
//   msg_data  : payload
interface noc_proc_injector_if;
    import noc_pkg::*;

    logic              msg_valid;
    logic              msg_ready;
    logic [DEST_W-1:0] msg_dest;
    logic [DATA_W-1:0] msg_data;

    modport master (output msg_valid, msg_dest, msg_data, input msg_ready);
    modport slave  (input msg_valid, msg_dest, msg_data, output msg_ready);
endinterface

// File: rtl/noc_tx_fifo.sv
// Message FIFO for the injector. Strict first-in first-out, head read
// combinationally from a registered read pointer.
//   clock, reset        : rising-edge clock, async active-low reset
//   push, push_data     : write (caller guarantees not full)
//   pop                 : read/advance (caller guarantees not empty)
//   head_c              : current head entry
//   full, empty         : registered occupancy flags
//   full_next_c/empty_next_c : flags as they will be after this edge
module noc_tx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 11
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_c,
    output logic             full,
    output logic             empty,
    output logic             full_next_c,
    output logic             empty_next_c
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;

    assign head_c = mem[rd_ptr];

    // Occupancy after this edge; simultaneous push and pop cancel.
    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = CNT_W'(count + 1'b1);
        end else if (!push && pop) begin
            count_next = CNT_W'(count - 1'b1);
        end
    end

    assign full_next_c  = (count_next == CNT_W'(DEPTH));
    assign empty_next_c = (count_next == '0);

    // Storage needs no reset; pointers and count define validity.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push) wr_ptr <= PTR_W'(wr_ptr + 1'b1);
            if (pop)  rd_ptr <= PTR_W'(rd_ptr + 1'b1);
            count <= count_next;
            full  <= full_next_c;
            empty <= empty_next_c;
        end
    end
endmodule

// File: rtl/noc_proc_injector.sv
// Queues local processor messages and injects them into the mesh as
// configure words held for HOLD_CYCLES clocks followed by GAP_CYCLES
// clocks of zero.
//   clock, reset    : rising-edge clock, async active-low reset
//   msg             : processor message handshake (slave side)
//   router_ready    : this processor's mesh ready bit
//   block_all_paths : global injection inhibit
//   configure       : {dest, data} to pN_configure, 0 when idle
//   busy            : driving, in gap, or messages queued
//   sent_count      : words launched, modulo 256
//   drop_pulse      : one-cycle pulse when a null message is discarded
module noc_proc_injector
    import noc_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned HOLD_CYCLES = 3,
    parameter int unsigned GAP_CYCLES  = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    noc_proc_injector_if.slave   msg,
    input  logic                 router_ready,
    input  logic                 block_all_paths,
    output logic [CFG_W-1:0]     configure,
    output logic                 busy,
    output logic [7:0]           sent_count,
    output logic                 drop_pulse
);
    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned GAP_W  = (GAP_CYCLES > 1)  ? $clog2(GAP_CYCLES)  : 1;

    tx_state_e         state, state_next;
    cfg_word_t         cfg_q, cfg_next;
    logic [HOLD_W-1:0] hold_cnt, hold_next;
    logic [GAP_W-1:0]  gap_cnt, gap_next;
    logic [7:0]        sent_q, sent_next;
    logic              ready_q, busy_q, drop_q;

    cfg_word_t         in_word;
    logic              accept, is_null, push, launch_ok, launch;
    logic [CFG_W-1:0]  fifo_head;
    logic              fifo_full, fifo_empty, full_next, empty_next;

    assign in_word   = '{dest: msg.msg_dest, data: msg.msg_data};
    assign accept    = msg.msg_valid && ready_q;
    // An all-zero word would read as idle on the mesh, so it is dropped.
    assign is_null   = (in_word == '0);
    assign push      = accept && !is_null && !fifo_full;
    // The final gap clock doubles as a launch slot so queued words start
    // HOLD_CYCLES + GAP_CYCLES clocks apart.
    assign launch_ok = (state == ST_IDLE) || (state == ST_GAP && gap_cnt == '0);
    assign launch    = launch_ok && !fifo_empty && router_ready && !block_all_paths;

    noc_tx_fifo #(.DEPTH(DEPTH), .WIDTH(CFG_W)) u_fifo (
        .clock        (clock),
        .reset        (reset),
        .push         (push),
        .push_data    (in_word),
        .pop          (launch),
        .head_c       (fifo_head),
        .full         (fifo_full),
        .empty        (fifo_empty),
        .full_next_c  (full_next),
        .empty_next_c (empty_next)
    );

    // State and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            cfg_q    <= '0;
            hold_cnt <= '0;
            gap_cnt  <= '0;
            sent_q   <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state    <= state_next;
            cfg_q    <= cfg_next;
            hold_cnt <= hold_next;
            gap_cnt  <= gap_next;
            sent_q   <= sent_next;
            ready_q  <= !full_next;
            busy_q   <= (state_next != ST_IDLE) || !empty_next;
            drop_q   <= accept && is_null;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (launch) state_next = ST_DRIVE;
            ST_DRIVE: if (hold_cnt == '0) state_next = ST_GAP;
            ST_GAP:   if (gap_cnt == '0) state_next = launch ? ST_DRIVE : ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Output / counter next values.
    always_comb begin
        cfg_next  = cfg_q;
        hold_next = hold_cnt;
        gap_next  = gap_cnt;
        sent_next = sent_q;
        if (launch) begin
            cfg_next  = cfg_word_t'(fifo_head);
            hold_next = HOLD_W'(HOLD_CYCLES - 1);
            sent_next = sent_q + 8'd1;
        end else begin
            case (state)
                ST_DRIVE: begin
                    if (hold_cnt == '0) begin
                        cfg_next = '0;
                        gap_next = GAP_W'(GAP_CYCLES - 1);
                    end else begin
                        hold_next = HOLD_W'(hold_cnt - 1'b1);
                    end
                end
                ST_GAP: begin
                    cfg_next = '0;
                    if (gap_cnt != '0) gap_next = GAP_W'(gap_cnt - 1'b1);
                end
                default: cfg_next = '0;
            endcase
        end
    end

    assign msg.msg_ready = ready_q;
    assign configure     = cfg_q;
    assign busy          = busy_q;
    assign sent_count    = sent_q;
    assign drop_pulse    = drop_q;
endmodule

// File: tb/tb_noc_proc_injector.sv
// Directed bench for noc_proc_injector (DEPTH=4, HOLD=3, GAP=1).
module tb_noc_proc_injector;

    logic        clock = 1'b0;
    logic        reset;
    logic        router_ready;
    logic        block_all_paths;
    logic [10:0] configure;
    logic        busy;
    logic [7:0]  sent_count;
    logic        drop_pulse;

    int vectors     = 0;
    int miscompares = 0;

    logic [10:0] w2 [5];

    noc_proc_injector_if mif ();

    noc_proc_injector #(.DEPTH(4), .HOLD_CYCLES(3), .GAP_CYCLES(1)) dut (
        .clock           (clock),
        .reset           (reset),
        .msg             (mif),
        .router_ready    (router_ready),
        .block_all_paths (block_all_paths),
        .configure       (configure),
        .busy            (busy),
        .sent_count      (sent_count),
        .drop_pulse      (drop_pulse)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic v, input logic [1:0] d, input logic [8:0] x);
        mif.msg_valid = v;
        mif.msg_dest  = d;
        mif.msg_data  = x;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        router_ready = 1'b0;
        block_all_paths = 1'b0;
        offer(1'b0, 2'd0, 9'd0);

        // Reset state
        repeat (2) tick();
        chk("rst_cfg",   32'(configure),  32'h0);
        chk("rst_busy",  32'(busy),       32'h0);
        chk("rst_sent",  32'(sent_count), 32'h0);
        chk("rst_ready", 32'(mif.msg_ready), 32'h0);
        chk("rst_drop",  32'(drop_pulse), 32'h0);
        #2 reset = 1'b1;
        #1 chk("ready_before_edge", 32'(mif.msg_ready), 32'h0);
        tick();
        chk("ready_after_edge", 32'(mif.msg_ready), 32'h1);

        // Single message dest=1 data=5
        router_ready = 1'b1;
        offer(1'b1, 2'd1, 9'd5);
        tick();
        offer(1'b0, 2'd0, 9'd0);
        chk("t1_busy_queued", 32'(busy), 32'h1);
        chk("t1_cfg_pre", 32'(configure), 32'h0);
        tick();
        chk("t1_cfg0", 32'(configure), 32'h205);
        chk("t1_sent", 32'(sent_count), 32'h1);
        tick();
        chk("t1_cfg1", 32'(configure), 32'h205);
        tick();
        chk("t1_cfg2", 32'(configure), 32'h205);
        tick();
        chk("t1_gap", 32'(configure), 32'h0);
        chk("t1_busy_gap", 32'(busy), 32'h1);
        tick();
        chk("t1_idle_busy", 32'(busy), 32'h0);
        chk("t1_idle_cfg", 32'(configure), 32'h0);

        // Fill FIFO with router not ready
        router_ready = 1'b0;
        for (int i = 0; i < 5; i++) w2[i] = 11'h410 + 11'(i);
        for (int i = 0; i < 4; i++) begin
            offer(1'b1, 2'd2, 9'h10 + 9'(i));
            tick();
            chk("t2_ready_fill", 32'(mif.msg_ready), (i < 3) ? 32'h1 : 32'h0);
        end
        offer(1'b1, 2'd2, 9'h14);
        tick();
        tick();
        chk("t2_fifth_held", 32'(mif.msg_ready), 32'h0);
        chk("t2_cfg_blocked", 32'(configure), 32'h0);
        chk("t2_busy", 32'(busy), 32'h1);
        router_ready = 1'b1;
        tick();
        chk("t2_w0", 32'(configure), 32'(w2[0]));
        chk("t2_ready_after_pop", 32'(mif.msg_ready), 32'h1);
        tick();
        offer(1'b0, 2'd0, 9'd0);
        chk("t2_full_again", 32'(mif.msg_ready), 32'h0);
        tick();
        tick();
        chk("t2_gap0", 32'(configure), 32'h0);
        tick();
        for (int k = 1; k < 5; k++) begin
            chk("t2_word", 32'(configure), 32'(w2[k]));
            tick();
            tick();
            tick();
            chk("t2_gap", 32'(configure), 32'h0);
            tick();
        end
        chk("t2_busy_done", 32'(busy), 32'h0);
        chk("t2_sent", 32'(sent_count), 32'h6);

        // block_all_paths holds two queued words
        block_all_paths = 1'b1;
        offer(1'b1, 2'd3, 9'h1AA);
        tick();
        offer(1'b1, 2'd1, 9'h0F0);
        tick();
        offer(1'b0, 2'd0, 9'd0);
        repeat (3) tick();
        chk("t3_blocked_cfg", 32'(configure), 32'h0);
        chk("t3_blocked_busy", 32'(busy), 32'h1);
        block_all_paths = 1'b0;
        tick();
        chk("t3_w0", 32'(configure), 32'h7AA);
        tick();
        tick();
        chk("t3_w0_hold", 32'(configure), 32'h7AA);
        tick();
        chk("t3_gap", 32'(configure), 32'h0);
        tick();
        chk("t3_w1", 32'(configure), 32'h2F0);
        block_all_paths = 1'b1;
        tick();
        tick();
        chk("t3_w1_ignores_block", 32'(configure), 32'h2F0);
        tick();
        chk("t3_gap1", 32'(configure), 32'h0);
        tick();
        chk("t3_busy_done", 32'(busy), 32'h0);
        chk("t3_sent", 32'(sent_count), 32'h8);
        block_all_paths = 1'b0;

        // Null message is dropped
        offer(1'b1, 2'd0, 9'd0);
        tick();
        offer(1'b0, 2'd0, 9'd0);
        chk("t4_drop", 32'(drop_pulse), 32'h1);
        chk("t4_empty", 32'(busy), 32'h0);
        tick();
        chk("t4_drop_end", 32'(drop_pulse), 32'h0);
        chk("t4_cfg", 32'(configure), 32'h0);
        chk("t4_sent", 32'(sent_count), 32'h8);

        // Reset mid-DRIVE
        offer(1'b1, 2'd2, 9'h155);
        tick();
        offer(1'b0, 2'd0, 9'd0);
        tick();
        chk("t5_cfg", 32'(configure), 32'h555);
        offer(1'b1, 2'd1, 9'h0AB);
        tick();
        offer(1'b0, 2'd0, 9'd0);
        #2 reset = 1'b0;
        #1;
        chk("t5_async_cfg",  32'(configure),  32'h0);
        chk("t5_async_sent", 32'(sent_count), 32'h0);
        chk("t5_async_busy", 32'(busy),       32'h0);
        chk("t5_async_ready", 32'(mif.msg_ready), 32'h0);
        #1 reset = 1'b1;
        tick();
        chk("t5_ready", 32'(mif.msg_ready), 32'h1);
        chk("t5_fifo_empty", 32'(busy), 32'h0);
        tick();
        chk("t5_no_launch", 32'(configure), 32'h0);

        // 256 launches wrap sent_count
        offer(1'b1, 2'd1, 9'd1);
        tick();
        tick();
        chk("t6_first", 32'(sent_count), 32'h1);
        chk("t6_cfg", 32'(configure), 32'h201);
        repeat (4 * 254) tick();
        chk("t6_255", 32'(sent_count), 32'hFF);
        repeat (4) tick();
        chk("t6_wrap", 32'(sent_count), 32'h0);
        offer(1'b0, 2'd0, 9'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
